// File: rtl/hazard_controller.sv
// Pipeline hazard controller: detects RAW hazards against in-flight destination
// registers and opens a squash window after a taken jump, with stall/squash counters.
module hazard_controller #(
  parameter int DEPTH         = 3,
  parameter int WB_FORWARD    = 0,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       a0,
  input  logic [4:0]       a1,
  input  logic [4:0]       a2_hazard,
  input  logic             jmp_taken,
  output logic             stall,
  output logic             squash,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] squash_events
);

  localparam int MATCH_N = DEPTH - WB_FORWARD;
  localparam int SQ_W    = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

  localparam logic [SQ_W-1:0]  SQ_RELOAD = SQ_W'(SQUASH_CYCLES - 1);
  localparam logic [SQ_W-1:0]  SQ_ONE    = SQ_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [4:0]      sb [DEPTH];
  logic [SQ_W-1:0] sq_cnt;
  logic            hit0;
  logic            hit1;

  // When the register file writes before it reads, the oldest slot is already visible.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int i = 0; i < MATCH_N; i++) begin
      if ((a0 != 5'd0) && (a0 == sb[i])) hit0 = 1'b1;
      if ((a1 != 5'd0) && (a1 == sb[i])) hit1 = 1'b1;
    end
  end

  assign squash = ~rst & (jmp_taken | (sq_cnt != '0));
  assign stall  = ~rst & ~squash & (hit0 | hit1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb[i] <= 5'd0;
      sq_cnt        <= '0;
      stall_cycles  <= '0;
      squash_events <= '0;
    end else begin
      // Bubbles and killed instructions never produce a result, so they enter as empty slots.
      sb[0] <= (stall | squash) ? 5'd0 : a2_hazard;
      for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];

      if (jmp_taken)
        sq_cnt <= SQ_RELOAD;
      else if (sq_cnt != '0)
        sq_cnt <= sq_cnt - SQ_ONE;

      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_ONE;
      if (jmp_taken && (squash_events != '1))
        squash_events <= squash_events + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: three builds (default, write-before-read, 4-bit counters)
// share one stimulus stream and are checked against a cycle-history model.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] a0 = '0;
  logic [4:0] a1 = '0;
  logic [4:0] a2_hazard = '0;
  logic       jmp_taken = 1'b0;

  logic        stall0, squash0, stall1, squash1, stall2, squash2;
  logic [31:0] sc0, se0, sc1, se1;
  logic [3:0]  sc2, se2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_controller dut0 (
    .clk(clk), .rst(rst), .a0(a0), .a1(a1), .a2_hazard(a2_hazard), .jmp_taken(jmp_taken),
    .stall(stall0), .squash(squash0), .stall_cycles(sc0), .squash_events(se0)
  );

  hazard_controller #(.WB_FORWARD(1)) dut1 (
    .clk(clk), .rst(rst), .a0(a0), .a1(a1), .a2_hazard(a2_hazard), .jmp_taken(jmp_taken),
    .stall(stall1), .squash(squash1), .stall_cycles(sc1), .squash_events(se1)
  );

  hazard_controller #(.CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .a0(a0), .a1(a1), .a2_hazard(a2_hazard), .jmp_taken(jmp_taken),
    .stall(stall2), .squash(squash2), .stall_cycles(sc2), .squash_events(se2)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change just after the rising edge and are observed at the following falling edge.
  task automatic applyStimulus(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] d,
                               input logic j, input logic r);
    @(posedge clk);
    #1;
    a0 = s0; a1 = s1; a2_hazard = d; jmp_taken = j; rst = r;
    @(negedge clk);
    #1;
  endtask

  // Model: a producer issued k cycles ago (after the last reset) is hazardous while k <= range.
  int         nrange [3] = '{3, 2, 3};
  longint     cmax   [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  logic [4:0] hist   [3][256];
  longint     cnt_st [3];
  longint     cnt_sq [3];
  int         cyc = 0;
  int         last_rst = -1;
  int         last_jmp = -100;
  bit         model_valid = 1'b0;
  bit         exp_stall, exp_squash;
  longint     act_st [3];
  longint     act_sq [3];
  longint     act_sc [3];
  longint     act_se [3];

  function automatic bit producedRecently(input int inst, input logic [4:0] r);
    producedRecently = 1'b0;
    if (r != 5'd0)
      for (int k = 1; k <= nrange[inst]; k++)
        if ((cyc - k > last_rst) && (cyc - k >= 0) && (hist[inst][cyc-k] == r))
          producedRecently = 1'b1;
  endfunction

  always @(negedge clk) begin
    act_st = '{longint'(stall0), longint'(stall1), longint'(stall2)};
    act_sq = '{longint'(squash0), longint'(squash1), longint'(squash2)};
    act_sc = '{longint'(sc0), longint'(sc1), longint'(sc2)};
    act_se = '{longint'(se0), longint'(se1), longint'(se2)};
    if (cyc >= 256) begin
      $display("[TB] FAIL history_overflow: got %0d expected below 256", cyc);
      $fatal(1, "[TB] model history exhausted");
    end
    for (int i = 0; i < 3; i++) begin
      exp_squash = !rst && (jmp_taken || ((last_jmp > last_rst) && (cyc - last_jmp < 2)));
      exp_stall  = !rst && !exp_squash &&
                   (producedRecently(i, a0) || producedRecently(i, a1));
      if (model_valid) begin
        checkOutput($sformatf("stall[%0d]@%0d", i, cyc), act_st[i], longint'(exp_stall));
        checkOutput($sformatf("squash[%0d]@%0d", i, cyc), act_sq[i], longint'(exp_squash));
        checkOutput($sformatf("stall_cycles[%0d]@%0d", i, cyc), act_sc[i], cnt_st[i]);
        checkOutput($sformatf("squash_events[%0d]@%0d", i, cyc), act_se[i], cnt_sq[i]);
      end
      if (rst) begin
        cnt_st[i] = 0;
        cnt_sq[i] = 0;
      end else begin
        hist[i][cyc] = (exp_stall || exp_squash) ? 5'd0 : a2_hazard;
        if (exp_stall && cnt_st[i] < cmax[i]) cnt_st[i]++;
        if (jmp_taken && cnt_sq[i] < cmax[i]) cnt_sq[i]++;
      end
    end
    if (rst) begin
      last_rst    = cyc;
      model_valid = 1'b1;
    end else if (jmp_taken) begin
      last_jmp = cyc;
    end
    cyc++;
  end

  initial begin
    // Reset with live-looking inputs
    applyStimulus(7, 7, 7, 0, 1);
    applyStimulus(7, 7, 7, 0, 1);
    checkOutput("reset_stall", stall0, 0);
    checkOutput("reset_squash", squash0, 0);
    checkOutput("reset_stall_cycles", sc0, 0);
    checkOutput("reset_squash_events", se0, 0);
    applyStimulus(7, 0, 0, 0, 0);
    checkOutput("post_reset_empty", stall0, 0);

    // RAW hazard on x5
    applyStimulus(0, 0, 5, 0, 0);
    applyStimulus(5, 0, 0, 0, 0);
    checkOutput("raw_c1", stall0, 1);
    checkOutput("raw_wbf_c1", stall1, 1);
    applyStimulus(5, 0, 0, 0, 0);
    checkOutput("raw_c2", stall0, 1);
    checkOutput("raw_wbf_c2", stall1, 1);
    applyStimulus(5, 0, 0, 0, 0);
    checkOutput("raw_c3", stall0, 1);
    checkOutput("raw_wbf_c3", stall1, 0);
    applyStimulus(5, 0, 0, 0, 0);
    checkOutput("raw_c4", stall0, 0);
    checkOutput("raw_count", sc0, 3);
    checkOutput("raw_wbf_count", sc1, 2);

    // x0 never hazards; unrelated registers never match
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("x0_stall", stall0, 0);
    applyStimulus(0, 0, 9, 0, 0);
    applyStimulus(3, 4, 0, 0, 0);
    checkOutput("nomatch_stall", stall0, 0);

    // Jump with a simultaneous match: squash wins
    applyStimulus(0, 0, 6, 0, 0);
    applyStimulus(0, 6, 0, 1, 0);
    checkOutput("jmp_c1_squash", squash0, 1);
    checkOutput("jmp_c1_stall", stall0, 0);
    applyStimulus(0, 6, 0, 0, 0);
    checkOutput("jmp_c2_squash", squash0, 1);
    checkOutput("jmp_c2_stall", stall0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("jmp_c3_squash", squash0, 0);
    checkOutput("jmp_events", se0, 1);

    // Back-to-back jumps restart the window
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("rejmp_c1_squash", squash0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rejmp_c2_squash", squash0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rejmp_c3_squash", squash0, 0);
    checkOutput("rejmp_events", se0, 2);

    // Persistent self-dependency drives the 4-bit counter into saturation
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 8, 0, 0);
    for (int i = 0; i < 26; i++) applyStimulus(8, 0, 8, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("sat_count_w4", sc2, 15);
    checkOutput("sat_count_w32", sc0, 20);

    // Reset in the middle of a stall
    applyStimulus(0, 0, 8, 0, 0);
    applyStimulus(8, 0, 0, 0, 0);
    checkOutput("midrst_pre_stall", stall0, 1);
    applyStimulus(8, 0, 0, 0, 1);
    checkOutput("midrst_stall", stall0, 0);
    applyStimulus(8, 0, 0, 0, 0);
    checkOutput("midrst_sb_empty", stall0, 0);
    checkOutput("midrst_count", sc0, 0);
    checkOutput("midrst_count_w4", sc2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
